// File: rtl/instruction_ram.sv
// instruction_ram: synchronous fetch-stage instruction memory with a power-on fill and a run-time program-load port.
// Revision 1.0

`default_nettype none

module instruction_ram #(
  parameter int              DATA_W    = 28,
  parameter int              ADDR_W    = 16,
  parameter int              DEPTH     = 256,
  parameter logic [DATA_W-1:0] FILL_WORD = 28'h00000AA
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iReadEnable,
  input  logic [ADDR_W-1:0] iAddress,
  output logic [DATA_W-1:0] oInstruction,
  output logic              oValid,
  input  logic              iWriteEnable,
  input  logic [ADDR_W-1:0] iWriteAddress,
  input  logic [DATA_W-1:0] iWriteData,
  output logic              oReady,
  output logic              oWriteError
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] init_count;
  logic [CNT_W-1:0] init_count_next;
  logic             init_we;
  logic             running;

  logic             rd_in_range;
  logic             wr_in_range;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Range checks widen by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign rd_in_range = ({1'b0, iAddress} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, iWriteAddress} < DEPTH_EXT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_INIT;
      init_count <= '0;
    end else begin
      state      <= state_next;
      init_count <= init_count_next;
    end
  end

  always_comb begin
    state_next      = state;
    init_count_next = init_count;
    case (state)
      ST_INIT: begin
        init_count_next = init_count + 1'b1;
        if (init_count == LAST_IDX) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next      = ST_INIT;
        init_count_next = '0;
      end
    endcase
  end

  always_comb begin
    init_we = 1'b0;
    running = 1'b0;
    oReady  = 1'b0;
    case (state)
      ST_INIT: init_we = 1'b1;
      ST_RUN: begin
        running = 1'b1;
        oReady  = 1'b1;
      end
      default: init_we = 1'b0;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_count[IDX_W-1:0];
    mem_wdata = FILL_WORD;
    if (init_we) begin
      mem_we = 1'b1;
    end else if (running && iWriteEnable && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = iWriteAddress[IDX_W-1:0];
      mem_wdata = iWriteData;
    end
  end

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read uses the pre-edge array contents, giving read-first on collisions.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oInstruction <= FILL_WORD;
      oValid       <= 1'b0;
    end else if (running && iReadEnable) begin
      oInstruction <= rd_in_range ? mem[iAddress[IDX_W-1:0]] : FILL_WORD;
      oValid       <= 1'b1;
    end else begin
      oValid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oWriteError <= 1'b0;
    end else begin
      oWriteError <= iWriteEnable && (!running || !wr_in_range);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_ram.sv
// tb_instruction_ram: directed self-checking bench for instruction_ram at DEPTH=16.
// Revision 1.0

`default_nettype none

module tb_instruction_ram;

  localparam int DATA_W = 28;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;
  localparam logic [DATA_W-1:0] FILL = 28'h00000AA;

  logic              Clock;
  logic              Reset;
  logic              iReadEnable;
  logic [ADDR_W-1:0] iAddress;
  logic [DATA_W-1:0] oInstruction;
  logic              oValid;
  logic              iWriteEnable;
  logic [ADDR_W-1:0] iWriteAddress;
  logic [DATA_W-1:0] iWriteData;
  logic              oReady;
  logic              oWriteError;

  int errors = 0;
  int checks = 0;

  instruction_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .FILL_WORD(FILL)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iReadEnable  (iReadEnable),
    .iAddress     (iAddress),
    .oInstruction (oInstruction),
    .oValid       (oValid),
    .iWriteEnable (iWriteEnable),
    .iWriteAddress(iWriteAddress),
    .iWriteData   (iWriteData),
    .oReady       (oReady),
    .oWriteError  (oWriteError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset         = 1'b1;
    iReadEnable   = 1'b1;
    iAddress      = 16'd3;
    iWriteEnable  = 1'b0;
    iWriteAddress = '0;
    iWriteData    = '0;
    step();
    step();
    check("rst_instr", 32'(oInstruction), 32'(FILL));
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_ready", 32'(oReady), 32'd0);
    check("rst_werr", 32'(oWriteError), 32'd0);

    // Release reset; a write attempted on INIT edge 2 must be flagged and dropped.
    Reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      iWriteEnable  = (k == 2);
      iWriteAddress = 16'd3;
      iWriteData    = 28'h0000123;
      step();
      check($sformatf("init_valid_%0d", k), 32'(oValid), 32'd0);
      check($sformatf("init_ready_%0d", k), 32'(oReady), (k == DEPTH) ? 32'd1 : 32'd0);
      check($sformatf("init_werr_%0d", k), 32'(oWriteError), (k == 2) ? 32'd1 : 32'd0);
    end
    iWriteEnable = 1'b0;
    step();
    check("first_valid", 32'(oValid), 32'd1);
    check("first_instr", 32'(oInstruction), 32'(FILL));

    // Program load then fetch.
    iReadEnable = 1'b0; iWriteEnable = 1'b1; iWriteAddress = 16'd5; iWriteData = 28'h1234567;
    step();
    check("wr5_werr", 32'(oWriteError), 32'd0);
    check("wr5_valid", 32'(oValid), 32'd0);
    iWriteEnable = 1'b0; iReadEnable = 1'b1; iAddress = 16'd5;
    step();
    check("rd5_instr", 32'(oInstruction), 32'h1234567);
    check("rd5_valid", 32'(oValid), 32'd1);

    // Same-edge read and write: old word first.
    iWriteEnable = 1'b1; iWriteAddress = 16'd7; iWriteData = 28'hABCDEF0; iAddress = 16'd7;
    step();
    check("rw7_old", 32'(oInstruction), 32'(FILL));
    iWriteEnable = 1'b0;
    step();
    check("rw7_new", 32'(oInstruction), 32'hABCDEF0);

    // Out-of-range reads.
    iAddress = 16'd16;
    step();
    check("rd16", 32'(oInstruction), 32'(FILL));
    iAddress = 16'd5;
    step();
    check("rd5_again", 32'(oInstruction), 32'h1234567);
    iAddress = 16'hFFFF;
    step();
    check("rdFFFF", 32'(oInstruction), 32'(FILL));

    // Out-of-range write: one-cycle error, no aliasing onto address 0.
    iReadEnable = 1'b0; iWriteEnable = 1'b1; iWriteAddress = 16'd16; iWriteData = 28'h5555555;
    step();
    check("wr16_werr", 32'(oWriteError), 32'd1);
    iWriteEnable = 1'b0; iReadEnable = 1'b1; iAddress = 16'd5;
    step();
    check("wr16_werr_clr", 32'(oWriteError), 32'd0);
    check("rd5_pre0", 32'(oInstruction), 32'h1234567);
    iAddress = 16'd0;
    step();
    check("rd0_fill", 32'(oInstruction), 32'(FILL));

    // Stall: output holds, valid low.
    iAddress = 16'd5;
    step();
    check("hold_pre", 32'(oInstruction), 32'h1234567);
    iReadEnable = 1'b0; iAddress = 16'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_instr_%0d", k), 32'(oInstruction), 32'h1234567);
      check($sformatf("hold_valid_%0d", k), 32'(oValid), 32'd0);
    end

    // Reset mid-run: immediate output reset, INIT repeats, programmed word gone.
    Reset = 1'b1;
    #1;
    check("mid_rst_instr", 32'(oInstruction), 32'(FILL));
    check("mid_rst_valid", 32'(oValid), 32'd0);
    check("mid_rst_ready", 32'(oReady), 32'd0);
    iReadEnable = 1'b1; iAddress = 16'd5;
    step();
    Reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      check($sformatf("reinit_ready_%0d", k), 32'(oReady), (k == DEPTH) ? 32'd1 : 32'd0);
      check($sformatf("reinit_valid_%0d", k), 32'(oValid), 32'd0);
    end
    step();
    check("post_rst_valid", 32'(oValid), 32'd1);
    check("post_rst_rd5", 32'(oInstruction), 32'(FILL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
